// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage: single-cycle logic/arith ops plus
// iterative unsigned multiply (shift-add) and divide (restoring) behind valid/ready.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             isZero,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_SLT  = 4'd4;
  localparam logic [3:0] F_LUI  = 4'd5;
  localparam logic [3:0] F_XOR  = 4'd6;
  localparam logic [3:0] F_NOR  = 4'd7;
  localparam logic [3:0] F_SLTU = 4'd8;
  localparam logic [3:0] F_MULU = 4'd9;
  localparam logic [3:0] F_DIVU = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_res_hi;
  logic               r_zero;
  logic               r_dbz;

  logic               w_accept;
  logic               w_long;
  logic               w_last;
  logic               w_load_simple;
  logic               w_load_long;
  logic [WIDTH-1:0]   w_simple;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_trial;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_div_hi;
  logic [WIDTH-1:0]   w_div_lo;
  logic [WIDTH-1:0]   w_long_res;
  logic [WIDTH-1:0]   w_long_hi;

  function automatic logic [WIDTH-1:0] f_simple(input logic [3:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    logic [WIDTH-1:0]        r;
    xs = x;
    ys = y;
    r  = '0;
    case (f)
      F_ADD:   r = x + y;
      F_SUB:   r = x - y;
      F_AND:   r = x & y;
      F_OR:    r = x | y;
      F_SLT:   r = {{(WIDTH-1){1'b0}}, (xs < ys)};
      F_LUI:   r = y << (WIDTH/2);
      F_XOR:   r = x ^ y;
      F_NOR:   r = ~(x | y);
      F_SLTU:  r = {{(WIDTH-1){1'b0}}, (x < y)};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign w_long        = (func == F_MULU) || (func == F_DIVU);
  assign in_ready      = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_last        = (r_cnt == CNT_W'(WIDTH-1));
  assign w_load_simple = w_accept && !w_long;
  assign w_load_long   = (r_state == BUSY) && w_last;
  assign w_simple      = f_simple(func, a, b);

  // Multiply step: r_hi accumulates, r_lo holds the multiplier shifting out LSB first
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // Divide step: r_hi is the partial remainder, r_lo shifts dividend out / quotient in
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opnd};
  assign w_div_ok    = !w_div_trial[WIDTH];
  assign w_div_hi    = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ok};

  assign w_long_res = r_is_div ? w_div_lo : w_mul_lo;
  assign w_long_hi  = r_is_div ? w_div_hi : w_mul_hi;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_long ? BUSY : DONE;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) w_state_nxt = w_long ? BUSY : DONE;
          else          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Iteration datapath: loaded at accept, no reset needed
  always_ff @(posedge clk) begin
    if (w_accept && w_long) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_is_div <= (func == F_DIVU);
      r_lo     <= (func == F_DIVU) ? a : b;
      r_opnd   <= (func == F_DIVU) ? b : a;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_hi  <= w_long_hi;
      r_lo  <= w_long_res;
    end
  end

  // Result registers: updated only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res    <= '0;
      r_res_hi <= '0;
      r_zero   <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_load_simple) begin
      r_res    <= w_simple;
      r_res_hi <= '0;
      r_zero   <= (w_simple == '0);
      r_dbz    <= 1'b0;
    end else if (w_load_long) begin
      r_res    <= w_long_res;
      r_res_hi <= w_long_hi;
      r_zero   <= (w_long_res == '0);
      r_dbz    <= r_is_div && (r_opnd == '0);
    end
  end

  assign out_valid   = (r_state == DONE);
  assign res         = r_res;
  assign res_hi      = r_res_hi;
  assign isZero      = r_zero;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed cases plus randomized ops against a reference model.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   func = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] res;
  logic [W-1:0] res_hi;
  logic         isZero;
  logic         div_by_zero;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_hi(res_hi), .isZero(isZero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         z;
    logic         d;
    int           acc;
    bit           chk_lat;
    int           lat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic [W-1:0] h,
                              input logic d, input bit cl, input int lat);
    exp_t e;
    e.r = r; e.h = h; e.z = (r == 0); e.d = d;
    e.acc = 0; e.chk_lat = cl; e.lat = lat;
    return e;
  endfunction

  // Reference model straight from the operation table
  function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0]  p;
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         d;
    int           lat;
    r = 0; h = 0; d = 0; lat = 1;
    case (f)
      0:  r = x + y;
      1:  r = x - y;
      2:  r = x & y;
      3:  r = x | y;
      4:  r = ($signed(x) < $signed(y)) ? 1 : 0;
      5:  r = y * (2 ** (W/2));
      6:  r = x ^ y;
      7:  r = ~(x | y);
      8:  r = (x < y) ? 1 : 0;
      9:  begin p = {32'b0, x} * {32'b0, y}; r = p[W-1:0]; h = p[2*W-1:W]; lat = W + 1; end
      10: begin
            lat = W + 1;
            if (y == 0) begin r = {W{1'b1}}; h = x; d = 1; end
            else begin r = x / y; h = x % y; end
          end
      default: r = 0;
    endcase
    return mk(r, h, d, 1'b0, lat);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      else begin
        mon_e = q.pop_front();
        chk("res", res, mon_e.r);
        chk("res_hi", res_hi, mon_e.h);
        chk("isZero", isZero, mon_e.z);
        chk("div_by_zero", div_by_zero, mon_e.d);
        if (mon_e.chk_lat) chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    bit got;
    got = 0;
    in_valid = 1'b1; func = f; a = x; b = y;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
      @(posedge clk); #1 out_ready = 1'b1;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    else begin e.acc = cyc; q.push_back(e); end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; func = 4'($urandom);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_res"}, res, 0);
    chk({nm, "_res_hi"}, res_hi, 0);
    chk({nm, "_isZero"}, isZero, 0);
    chk({nm, "_dbz"}, div_by_zero, 0);
    chk({nm, "_in_ready"}, in_ready, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  initial begin
    logic [3:0]   f;
    logic [W-1:0] x;
    logic [W-1:0] y;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 chk_reset_vals("post_rst");

    // ADD wrap to zero, one-cycle out_valid pulse
    issue(4'd0, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 32'h0, 1'b0, 1'b1, 1));
    @(posedge clk); #1 chk("add_pulse_end", out_valid, 0);

    issue(4'd4, 32'hFFFF_FFFF, 32'h1, mk(32'h1, 32'h0, 1'b0, 1'b1, 1));
    issue(4'd8, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 32'h0, 1'b0, 1'b1, 1));
    issue(4'd5, 32'h0, 32'h1234, mk(32'h1234_0000, 32'h0, 1'b0, 1'b1, 1));
    issue(4'd13, 32'h55, 32'h66, mk(32'h0, 32'h0, 1'b0, 1'b1, 1));

    // MULU max operands; in_valid during BUSY must be ignored
    issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h1, 32'hFFFF_FFFE, 1'b0, 1'b1, W + 1));
    for (int i = 0; i < W; i++) begin
      chk("busy_in_ready", in_ready, 0);
      in_valid = 1'b1; func = 4'd0; a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mul_done_valid", out_valid, 1);

    issue(4'd10, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b1, W + 1));
    issue(4'd10, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1, W + 1));
    drain();

    // Backpressure hold on SUB, then simultaneous release and OR accept
    @(posedge clk); #1 out_ready = 1'b0;
    issue(4'd1, 32'd10, 32'd3, mk(32'd7, 32'd0, 1'b0, 1'b0, 1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_res", res, 32'd7);
      chk("hold_res_hi", res_hi, 0);
      chk("hold_isZero", isZero, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    issue(4'd3, 32'hF0F0_0000, 32'h0000_0F0F, mk(32'hF0F0_0F0F, 32'h0, 1'b0, 1'b1, 1));
    drain();

    // Asynchronous reset in the middle of a MULU
    @(posedge clk); #1;
    issue(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0, 32'h0, 1'b0, 1'b0, W + 1));
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    #1 chk_reset_vals("mid_busy_rst");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", out_valid, 0);
    end
    @(posedge clk); #1;
    issue(4'd0, 32'd40, 32'd2, mk(32'd42, 32'h0, 1'b0, 1'b1, 1));
    drain();

    // Randomized traffic with random backpressure
    @(posedge clk); #1;
    for (int n = 0; n < 300; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      f = 4'($urandom_range(0, 15));
      if ((f == 4'd9 || f == 4'd10) && $urandom_range(0, 2) != 0) f = 4'($urandom_range(0, 8));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 15));
        1: y = 0;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 0;
      issue(f, x, y, model(f, x, y));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
